iter_muldiv: RTL
================

# iter_muldiv

Parametrised iterative multiply/divide unit serving the EX stage. It replaces the fixed 32-bit serial divider with one shared datapath that runs signed or unsigned multiply (shift-add) and divide (restoring, radix-2) at configurable width. EX drives start/annul/op/operands and holds `start_i` high while it stalls the pipeline. EX writes the `{hi,lo}` result to HI/LO once `ready_o` is seen.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 4. Result is 2·WIDTH.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset rst, synchronous, active-high
- `start_i`  in  1  request; held high by EX until it samples `ready_o`
- `annul_i`  in  1  abort current operation (flush/exception)
- `op_i`  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- `a_i`  in  WIDTH  multiplicand / dividend
- `b_i`  in  WIDTH  multiplier / divisor
- `result_o`  out  2·WIDTH  MUL: full product. DIV: {remainder, quotient}, i.e. hi=remainder, lo=quotient
- `ready_o`  out  1  result valid
- `busy_o`  out  1  operation in progress (state ≠ IDLE and ≠ END)
- `dbz_o`  out  1  divide-by-zero flag, valid while `ready_o`

## Operation
- States: IDLE, DBZ, RUN, END.
- **IDLE**
  - `start_i`=1 and `annul_i`=0 → latch `op_i`, `a_i`, `b_i`; clear iteration counter.
  - Next state is DBZ if the op is DIV/DIVU and `b_i`=0, otherwise RUN.
  - Operands are captured only in IDLE; changes on `a_i`/`b_i`/`op_i` afterwards are ignored.
- **Signed ops**: operands are converted to magnitude (two's-complement negate if MSB=1) at latch time. The core always runs unsigned.
- **RUN, MUL**: one shift-add step per cycle over a 2·WIDTH accumulator.
- **RUN, DIV**: one restoring step per cycle.
  - Shift the {rem, quot} register left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If non-negative, commit the difference and set quot LSB to 1.
- **RUN exit**: after exactly WIDTH iterations → END, with sign fix-up applied as the final registered result.
  - MUL: product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - MIN_INT / −1 (signed): quotient wraps to MIN_INT, remainder 0. No trap.
- **DBZ** → END next cycle with `result_o`=0 and `dbz_o`=1.
- **END**
  - `ready_o`=1; `result_o`/`dbz_o` held stable.
  - Stays in END while `start_i`=1.
  - `start_i`=0 → IDLE; `result_o` cleared to 0 and `dbz_o` cleared on that edge.
- **Annul**
  - `annul_i`=1 in any state → IDLE on next edge, `result_o`=0, no `ready_o` pulse.
  - Annul beats start in IDLE.
- **Reset**
  - `rst`=1 on any edge, including mid-operation → IDLE.
  - All outputs 0: `result_o`=0, `ready_o`=0, `busy_o`=0, `dbz_o`=0.

## Timing
- Edge E0 samples `start_i` in IDLE.
- Normal op: `busy_o`=1 from E0; state RUN for edges E0+1 … E0+WIDTH.
  - `ready_o` rises after edge E0+WIDTH.
  - WIDTH cycles of stall; 32 for the default instance.
- Divide by zero: `ready_o` rises after E0+1.
- Return to IDLE: `ready_o` falls on the first edge with `start_i`=0 in END.
  - A new operation can be accepted on the following edge, giving 1 idle cycle minimum between ops.
- Outputs are registered; no combinational path from inputs to outputs.
- Iteration counter width is clog2(WIDTH)+1 and must not wrap inside RUN.

## Test plan
- **DIVU**, WIDTH=32, a=100, b=7, `start_i` held → `ready_o` after exactly 32 edges.
  - Required: `result_o`=0x00000002_0000000E, `dbz_o`=0.
  - Then drop `start_i` → `ready_o`=0 and `result_o`=0 next edge.
- **Signed DIV**, a=−7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Also MIN_INT / −1 → quotient 0x80000000, remainder 0.
- **Signed MUL**, a=−3, b=5 → `result_o`=0xFFFFFFFF_FFFFFFF1.
  - Also MULU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE_00000001.
- **Divide by zero**: DIV with b=0 → `ready_o` after 1 edge, `dbz_o`=1, `result_o`=0.
  - `busy_o` low again after `start_i` drops.
- **Annul / reset**
  - `annul_i` pulsed at edge E0+10 of a DIVU → IDLE, no `ready_o`; a new DIVU 9/3 started next cycle yields lo=3, hi=0.
  - `rst` asserted mid-RUN → all outputs 0 on next edge.
  - Operands changed during RUN do not affect the result.
- **WIDTH=8 instance**: signed DIV −128/−1 → lo=0x80, hi=0x00 after 8 edges; MUL signed 0x80×0x80 → 0x4000.

Source files
------------

// File: rtl/iter_muldiv.sv
module iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dbz_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBZ,
    S_RUN,
    S_END
  } state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_top, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next;
  logic [WIDTH-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix, result_fix;

  always_comb begin
    a_neg = op_i[0] & a_i[WIDTH-1];
    b_neg = op_i[0] & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    // Multiply: {hi, lo} starts as {0, multiplier}; add multiplicand into hi on lo[0], then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: trial-subtract against the upper WIDTH+1 bits of {rem, quot} << 1.
    div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_top - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end

    step_next = is_div_q ? div_next : mul_next;

    quo_mag  = step_next[WIDTH-1:0];
    rem_mag  = step_next[2*WIDTH-1:WIDTH];
    quo_fix  = neg_lo_q ? -quo_mag : quo_mag;
    rem_fix  = neg_hi_q ? -rem_mag : rem_mag;
    prod_fix = neg_lo_q ? -step_next : step_next;
    result_fix = is_div_q ? {rem_fix, quo_fix} : prod_fix;
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = ready_q;
    dbz_d    = dbz_q;

    if (annul_i) begin
      state_d  = S_IDLE;
      result_d = '0;
      ready_d  = 1'b0;
      dbz_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_d = op_i[1];
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = op_i[1] & a_neg;
            cnt_d    = '0;
            if (op_i[1]) begin
              opb_d = b_mag;
              acc_d = {{WIDTH{1'b0}}, a_mag};
            end else begin
              opb_d = a_mag;
              acc_d = {{WIDTH{1'b0}}, b_mag};
            end
            state_d = (op_i[1] && (b_i == '0)) ? S_DBZ : S_RUN;
          end
        end
        S_DBZ: begin
          state_d  = S_END;
          result_d = '0;
          dbz_d    = 1'b1;
          ready_d  = 1'b1;
        end
        S_RUN: begin
          acc_d = step_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d  = S_END;
            result_d = result_fix;
            dbz_d    = 1'b0;
            ready_d  = 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state_d  = S_IDLE;
            result_d = '0;
            ready_d  = 1'b0;
            dbz_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DBZ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign dbz_o    = dbz_q;

endmodule
